mult_div_unit: RTL and testbench

- Parametrised iterative multiply/divide unit for the multicycle datapath; successor to the fixed 32-bit MultDiv.
- Width is generic, and signed/unsigned is a per-operation mode.
- Provides an explicit start/busy/done handshake, so the control FSM waits on done instead of counting cycles.
- Results go to the HI/LO result registers, which are held inside this block.

---
 rtl/mult_div_unit.sv | 173 +++++++++++++++++
 tb/tb_mult_div_unit.sv | 174 +++++++++++++++++
 2 files changed

// File: rtl/mult_div_unit.sv
`default_nettype none
// ============================================================================
// Module   : mult_div_unit
// Brief    : Iterative radix-2 multiply / restoring divide with HI/LO results.
//            Optional macro MULTDIV_EARLY_EXIT_EN ends mult early on zero bits.
// Revision : 1.0 - initial release
// ============================================================================
module mult_div_unit #(
    parameter int WIDTH = 32,
    parameter int CNT_W = $clog2(WIDTH) + 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic             is_signed,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic             div_zero,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_FIX  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t               state, state_nxt;
    logic [2*WIDTH-1:0]   acc;        // mult: product; div: remainder in upper half
    logic [2*WIDTH-1:0]   mcand;      // mult: shifted multiplicand; div: divisor in lower half
    logic [WIDTH-1:0]     mplier;     // mult: multiplier; div: dividend shifting into quotient
    logic [CNT_W-1:0]     cnt;
    logic                 is_mult;
    logic                 neg_res;
    logic                 neg_rem;
    logic                 zero_flag;

    logic                 w_start_ok;
    logic                 w_a_neg;
    logic                 w_b_neg;
    logic [WIDTH-1:0]     w_a_mag;
    logic [WIDTH-1:0]     w_b_mag;
    logic                 w_div0_req;
    logic [WIDTH:0]       w_shifted;
    logic [WIDTH:0]       w_divisor;
    logic                 w_qbit;
    logic [WIDTH-1:0]     w_rem_nxt;
    logic [2*WIDTH-1:0]   w_prod_fix;
    logic [WIDTH-1:0]     w_quot_fix;
    logic [WIDTH-1:0]     w_rem_fix;

    assign w_start_ok = start && ((op == 2'b01) || (op == 2'b10));
    assign w_a_neg    = is_signed & a[WIDTH-1];
    assign w_b_neg    = is_signed & b[WIDTH-1];
    // |most-negative| is 2^(WIDTH-1), which still fits as an unsigned magnitude
    assign w_a_mag    = w_a_neg ? -a : a;
    assign w_b_mag    = w_b_neg ? -b : b;
    assign w_div0_req = (op == 2'b10) && (b == '0);

    assign w_shifted  = {acc[2*WIDTH-1:WIDTH], mplier[WIDTH-1]};
    assign w_divisor  = {1'b0, mcand[WIDTH-1:0]};
    assign w_qbit     = (w_shifted >= w_divisor);
    assign w_rem_nxt  = w_qbit ? WIDTH'(w_shifted - w_divisor) : WIDTH'(w_shifted);

    assign w_prod_fix = neg_res ? -acc : acc;
    assign w_quot_fix = neg_res ? -mplier : mplier;
    assign w_rem_fix  = neg_rem ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];

    assign busy = (state != S_IDLE);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: begin
                if (w_start_ok) begin
                    state_nxt = w_div0_req ? S_DONE : S_RUN;
                end
            end
            S_RUN: begin
                if (cnt == CNT_W'(1)) begin
                    state_nxt = S_FIX;
                end
`ifdef MULTDIV_EARLY_EXIT_EN
                else if (is_mult && ((mplier >> 1) == '0)) begin
                    state_nxt = S_FIX;
                end
`endif
            end
            S_FIX:   state_nxt = S_DONE;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            acc       <= '0;
            mcand     <= '0;
            mplier    <= '0;
            cnt       <= '0;
            is_mult   <= 1'b0;
            neg_res   <= 1'b0;
            neg_rem   <= 1'b0;
            zero_flag <= 1'b0;
            done      <= 1'b0;
            div_zero  <= 1'b0;
            hi        <= '0;
            lo        <= '0;
        end else begin
            done     <= 1'b0;
            div_zero <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (w_start_ok) begin
                        is_mult   <= (op == 2'b01);
                        neg_res   <= w_a_neg ^ w_b_neg;
                        neg_rem   <= w_a_neg;
                        zero_flag <= w_div0_req;
                        acc       <= '0;
                        cnt       <= CNT_W'(WIDTH);
                        if (op == 2'b01) begin
                            mcand  <= {{WIDTH{1'b0}}, w_a_mag};
                            mplier <= w_b_mag;
                        end else begin
                            mcand  <= {{WIDTH{1'b0}}, w_b_mag};
                            mplier <= w_a_mag;
                        end
                    end
                end
                S_RUN: begin
                    cnt <= cnt - CNT_W'(1);
                    if (is_mult) begin
                        if (mplier[0]) begin
                            acc <= acc + mcand;
                        end
                        mcand  <= mcand << 1;
                        mplier <= mplier >> 1;
                    end else begin
                        acc[2*WIDTH-1:WIDTH] <= w_rem_nxt;
                        mplier               <= {mplier[WIDTH-2:0], w_qbit};
                    end
                end
                S_FIX: begin
                    if (is_mult) begin
                        hi <= w_prod_fix[2*WIDTH-1:WIDTH];
                        lo <= w_prod_fix[WIDTH-1:0];
                    end else begin
                        hi <= w_rem_fix;
                        lo <= w_quot_fix;
                    end
                end
                default: begin
                    done     <= 1'b1;
                    div_zero <= zero_flag;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_mult_div_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_mult_div_unit
// Brief    : Scoreboard bench for mult_div_unit with directed vectors.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mult_div_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [1:0]  op;
    logic        is_signed;
    logic [31:0] a, b;
    logic        busy, done, div_zero;
    logic [31:0] hi, lo;

    typedef struct {
        logic [31:0] hi;
        logic [31:0] lo;
        logic        dz;
        logic        mult;
        int          due;
    } exp_t;

    exp_t exp_q[$];
    int   n_tests = 0;
    int   n_fail  = 0;
    int   cyc     = 0;

    mult_div_unit #(.WIDTH(32)) dut (
        .clk(clk), .reset(reset), .start(start), .op(op), .is_signed(is_signed),
        .a(a), .b(b), .busy(busy), .done(done), .div_zero(div_zero),
        .hi(hi), .lo(lo)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: every done pulse must match the oldest pending expectation
    always @(negedge clk) begin
        if (!reset) begin
            if (div_zero && !done) check("div_zero_without_done", 32'(div_zero), 32'd0);
            if (done) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_done", 32'(done), 32'd0);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    check("hi", hi, e.hi);
                    check("lo", lo, e.lo);
                    check("div_zero", 32'(div_zero), 32'(e.dz));
`ifdef MULTDIV_EARLY_EXIT_EN
                    if (e.mult) check("latency_le", 32'(cyc <= e.due), 32'd1);
                    else        check("latency", 32'(cyc), 32'(e.due));
`else
                    check("latency", 32'(cyc), 32'(e.due));
`endif
                end
            end
        end
    end

    // Drive a start at a negedge; return after edge 0 with start dropped
    task automatic issue(input logic [1:0] o, input logic s, input logic [31:0] va,
                         input logic [31:0] vb, input logic [31:0] ehi, input logic [31:0] elo,
                         input logic edz, input int lat, input logic push);
        exp_t e;
        op = o; is_signed = s; a = va; b = vb; start = 1'b1;
        if (push) begin
            e.hi = ehi; e.lo = elo; e.dz = edz; e.mult = (o == 2'b01); e.due = cyc + 1 + lat;
            exp_q.push_back(e);
        end
        @(negedge clk);
        start = 1'b0;
        check("busy_after_start", 32'(busy), 32'd1);
    endtask

    task automatic finish_op(input int remaining);
        repeat (remaining) @(negedge clk);
        check("busy_after_done", 32'(busy), 32'd0);
        @(negedge clk);
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; op = 2'b00; is_signed = 1'b0; a = '0; b = '0;
        repeat (3) @(negedge clk);
        check("reset_busy", 32'(busy), 32'd0);
        check("reset_done", 32'(done), 32'd0);
        check("reset_hi", hi, 32'd0);
        check("reset_lo", lo, 32'd0);
        reset = 1'b0;
        @(negedge clk);

        // Unsigned mult with busy checked just before and at the done cycle
        issue(2'b01, 1'b0, 32'hFFFF_FFFF, 32'd2, 32'h0000_0001, 32'hFFFF_FFFE, 1'b0, 34, 1'b1);
        repeat (33) @(negedge clk);
        check("busy_edge33", 32'(busy), 32'd1);
        finish_op(1);

        issue(2'b01, 1'b1, -32'sd3, 32'd7, 32'hFFFF_FFFF, 32'hFFFF_FFEB, 1'b0, 34, 1'b1);
        finish_op(34);
        issue(2'b10, 1'b1, -32'sd7, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0, 34, 1'b1);
        finish_op(34);
        issue(2'b10, 1'b0, 32'd100, 32'd7, 32'd2, 32'd14, 1'b0, 34, 1'b1);
        finish_op(34);
        issue(2'b10, 1'b0, 32'h451, 32'h20, 32'h11, 32'h22, 1'b0, 34, 1'b1);
        finish_op(34);
        // Div by zero keeps the previous hi/lo
        issue(2'b10, 1'b0, 32'd5, 32'd0, 32'h11, 32'h22, 1'b1, 1, 1'b1);
        finish_op(1);
        issue(2'b10, 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 32'h8000_0000, 1'b0, 34, 1'b1);
        finish_op(34);
        issue(2'b01, 1'b1, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0, 1'b0, 34, 1'b1);
        finish_op(34);
        issue(2'b01, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h1, 1'b0, 34, 1'b1);
        finish_op(34);

        // No-op codes must not start anything
        op = 2'b11; start = 1'b1; a = 32'd9; b = 32'd9;
        @(negedge clk);
        check("noop11_busy", 32'(busy), 32'd0);
        op = 2'b00;
        @(negedge clk);
        check("noop00_busy", 32'(busy), 32'd0);
        start = 1'b0;

        // Second start at edge 5 is ignored
        issue(2'b01, 1'b0, 32'd6, 32'd7, 32'd0, 32'd42, 1'b0, 34, 1'b1);
        repeat (4) @(negedge clk);
        op = 2'b10; a = 32'd1; b = 32'd0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        finish_op(29);
        repeat (5) @(negedge clk);

        // Reset at edge 10 aborts the mult with no done pulse
        issue(2'b01, 1'b0, 32'd3, 32'd5, 32'd0, 32'd0, 1'b0, 34, 1'b0);
        repeat (9) @(negedge clk);
        @(posedge clk);
        #1 reset = 1'b1;
        #1;
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_hi", hi, 32'd0);
        check("abort_lo", lo, 32'd0);
        check("abort_done", 32'(done), 32'd0);
        @(negedge clk);
        reset = 1'b0;
        repeat (40) @(negedge clk);

        issue(2'b01, 1'b0, 32'd3, 32'd5, 32'd0, 32'd15, 1'b0, 34, 1'b1);
        finish_op(34);

        check("queue_empty", 32'(exp_q.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
